// File: rtl/seq_mult.sv
// -----------------------------------------------------------------------------
// seq_mult -- sequential shift-add multiplier, signed or unsigned operands.
//
// One operand set is accepted per operation through a valid/ready handshake.
// The product is built one multiplier bit per cycle in a private accumulator.
// It is published on p only when the last bit is done, and then held until
// the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand set offered on a/b/is_signed
//   in_ready   high in IDLE: an offered operand set is accepted this edge
//   a, b       multiplicand / multiplier, WIDTH bits
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   out_valid  p holds a completed product (DONE)
//   out_ready  consumer takes p; honoured only in DONE
//   p          2*WIDTH-bit product; keeps the last result until the next one
//   busy       high in CALC and DONE
// -----------------------------------------------------------------------------
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [2*WIDTH-1:0]   r_acc;     // running sum of partial products
  logic [2*WIDTH-1:0]   r_mcand;   // extended multiplicand, shifted left per bit
  logic [WIDTH-1:0]     r_mplier;  // multiplier, shifted right per bit
  logic                 r_signed;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_p;

  logic                 w_accept;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0]   w_acc_next;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_count == LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: assigning a default first means every path drives w_state_next, so
  // no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_CALC;
      S_CALC:  if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (Moore: a function of state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_CALC:  busy     = 1'b1;
      S_DONE:  begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // In signed mode the top multiplier bit carries weight -2^(WIDTH-1), so its
  // partial product is subtracted rather than added. The multiplicand is
  // sign-extended to 2*WIDTH bits, so all arithmetic is exact modulo 2^(2W).
  assign w_pp       = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = (r_signed && w_last) ? (r_acc - w_pp) : (r_acc + w_pp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_signed <= 1'b0;
      r_count  <= '0;
      r_p      <= '0;
    end else if (w_accept) begin
      // Latch the operands; later changes on a/b/is_signed are invisible.
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{is_signed & a[WIDTH-1]}}, a};
      r_mplier <= b;
      r_signed <= is_signed;
      r_count  <= '0;
    end else if (r_state == S_CALC) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_last) begin
        r_count <= '0;
        r_p     <= w_acc_next;   // publish only the finished product
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign p = r_p;

endmodule

// File: tb/tb_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_mult -- bench for seq_mult at WIDTH=8 and WIDTH=2.
// A behavioural model (state plus an arithmetically computed product) predicts
// in_ready/out_valid/busy/p. A compare process checks those outputs on every
// falling edge. Directed vectors carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_seq_mult;

  logic clk;
  logic rst;

  // WIDTH = 8 instance
  logic        iv8, ir8, s8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  // WIDTH = 2 instance
  logic        iv2, ir2, s2, ov2, or2, busy2;
  logic [1:0]  a2, b2;
  logic [3:0]  p2;

  int n_vec = 0;
  int n_err = 0;

  seq_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
  );

  seq_mult #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .is_signed(s2), .out_valid(ov2), .out_ready(or2), .p(p2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_CALC, M_DONE} mstate_t;

  function automatic logic [15:0] prod8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int xi, yi;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    return 16'(xi * yi);
  endfunction

  function automatic logic [3:0] prod2(input logic [1:0] x, input logic [1:0] y, input logic s);
    int xi, yi;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    return 4'(xi * yi);
  endfunction

  mstate_t     m8_st = M_IDLE;
  int          m8_cnt = 0;
  logic [15:0] m8_prod = '0;
  logic [15:0] m8_p = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_st  <= M_IDLE;
      m8_cnt <= 0;
      m8_p   <= '0;
    end else begin
      case (m8_st)
        M_IDLE: if (iv8) begin
          m8_st   <= M_CALC;
          m8_cnt  <= 0;
          m8_prod <= prod8(a8, b8, s8);
        end
        M_CALC: begin
          m8_cnt <= m8_cnt + 1;
          if (m8_cnt + 1 == 8) begin
            m8_st <= M_DONE;
            m8_p  <= m8_prod;
          end
        end
        M_DONE: if (or8) m8_st <= M_IDLE;
        default: m8_st <= M_IDLE;
      endcase
    end
  end

  mstate_t     m2_st = M_IDLE;
  int          m2_cnt = 0;
  logic [3:0]  m2_prod = '0;
  logic [3:0]  m2_p = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m2_st  <= M_IDLE;
      m2_cnt <= 0;
      m2_p   <= '0;
    end else begin
      case (m2_st)
        M_IDLE: if (iv2) begin
          m2_st   <= M_CALC;
          m2_cnt  <= 0;
          m2_prod <= prod2(a2, b2, s2);
        end
        M_CALC: begin
          m2_cnt <= m2_cnt + 1;
          if (m2_cnt + 1 == 2) begin
            m2_st <= M_DONE;
            m2_p  <= m2_prod;
          end
        end
        M_DONE: if (or2) m2_st <= M_IDLE;
        default: m2_st <= M_IDLE;
      endcase
    end
  end

  // Compare process: every falling edge, both instances
  always @(negedge clk) begin
    check("in_ready8",  32'(ir8),   32'(m8_st == M_IDLE));
    check("out_valid8", 32'(ov8),   32'(m8_st == M_DONE));
    check("busy8",      32'(busy8), 32'(m8_st != M_IDLE));
    check("p8",         32'(p8),    32'(m8_p));
    check("in_ready2",  32'(ir2),   32'(m2_st == M_IDLE));
    check("out_valid2", 32'(ov2),   32'(m2_st == M_DONE));
    check("busy2",      32'(busy2), 32'(m2_st != M_IDLE));
    check("p2",         32'(p2),    32'(m2_p));
  end

  // ---------------------------------------------------------------------------
  // Directed operations (entered and left at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        input logic [15:0] exp, input int hold, input bit scramble,
                        input string name);
    int k;
    a8 = ta; b8 = tb; s8 = ts; iv8 = 1'b1; or8 = (hold == 0);
    @(negedge clk);                      // accept edge E0 has passed
    iv8 = 1'b0;
    check({name, "_busy_after_accept"}, 32'(busy8), 32'd1);
    if (scramble) begin
      a8 = 8'd7; b8 = 8'd7; s8 = ~ts;
    end
    k = 0;
    while (!ov8 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 32'(k), 32'd8);
    check({name, "_p"}, 32'(p8), 32'(exp));
    if (hold > 0) begin
      iv8 = 1'b1;                        // must be ignored in DONE
      repeat (hold) begin
        @(negedge clk);
        check({name, "_hold_ov"}, 32'(ov8), 32'd1);
        check({name, "_hold_ir"}, 32'(ir8), 32'd0);
        check({name, "_hold_p"},  32'(p8),  32'(exp));
      end
      iv8 = 1'b0;
      or8 = 1'b1;
    end
    @(negedge clk);                      // handshake edge has passed
    check({name, "_ir_after"},   32'(ir8),   32'd1);
    check({name, "_ov_after"},   32'(ov8),   32'd0);
    check({name, "_busy_after"}, 32'(busy8), 32'd0);
    check({name, "_p_retained"}, 32'(p8),    32'(exp));
  endtask

  task automatic do_op2(input logic [1:0] ta, input logic [1:0] tb,
                        input logic [3:0] exp, input string name);
    int k;
    a2 = ta; b2 = tb; s2 = 1'b1; iv2 = 1'b1; or2 = 1'b1;
    @(negedge clk);
    iv2 = 1'b0;
    k = 0;
    while (!ov2 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 32'(k), 32'd2);
    check({name, "_p"}, 32'(p2), 32'(exp));
    @(negedge clk);
    check({name, "_ir_after"}, 32'(ir2), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; s8 = 1'b0;
    iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0; s2 = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_p8",   32'(p8),    32'd0);
    check("rst_ir8",  32'(ir8),   32'd1);
    check("rst_ov8",  32'(ov8),   32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Offered in the same cycle reset drops: taken on the first rising edge.
    do_op8(8'h80, 8'h80, 1'b1, 16'h4000, 0, 1'b0, "s_m128_m128");
    do_op8(8'h80, 8'h7F, 1'b1, 16'hC080, 0, 1'b0, "s_m128_127");
    do_op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 1'b0, "u_255_255");
    do_op8(8'd0,  8'd200, 1'b0, 16'h0000, 0, 1'b0, "u_0_200");
    do_op8(8'hFF, 8'hFF, 1'b1, 16'h0001, 0, 1'b0, "s_m1_m1");
    do_op8(8'd12, 8'd13, 1'b0, 16'h009C, 5, 1'b0, "backpressure");
    do_op8(8'd3,  8'd5,  1'b0, 16'h000F, 0, 1'b1, "latch_operands");
    do_op8(8'hF6, 8'd10, 1'b1, 16'hFF9C, 0, 1'b0, "s_m10_10");
    do_op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 1'b0, "u_255_255_b");

    // Abort three cycles into CALC
    a8 = 8'd100; b8 = 8'd100; s8 = 1'b0; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ov",   32'(ov8),   32'd0);
    check("abort_ir",   32'(ir8),   32'd1);
    check("abort_p",    32'(p8),    32'd0);
    check("abort_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_ov", 32'(ov8), 32'd0);
    end
    do_op8(8'd6, 8'd7, 1'b0, 16'h002A, 0, 1'b0, "after_abort");

    // WIDTH=2 signed: pinned literals, then all 16 pairs
    do_op2(2'b10, 2'b10, 4'b0100, "w2_m2_m2");
    do_op2(2'b10, 2'b01, 4'b1110, "w2_m2_1");
    for (int i = -2; i <= 1; i++) begin
      for (int j = -2; j <= 1; j++) begin
        do_op2(2'(i), 2'(j), 4'(i * j), "w2_sweep");
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
